// File: rtl/vip_uart_tx_ext_pkg.sv
// rtl/vip_uart_tx_ext_pkg.sv - shared state encoding and register set for the UART TX VIP
package vip_uart_tx_ext_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Sized for the widest supported frame (9 payload bits, 32-bit bit period).
    typedef struct packed {
        tx_state_t   state;
        logic [31:0] sample;
        logic [31:0] scaler;
        logic [8:0]  shiftreg;
        logic [3:0]  bitpos;
        logic        par;
        logic        par_en;
        logic        stop2;
        logic        tx;
        logic        overflow;
    } tx_regs_t;

    localparam tx_regs_t TX_REGS_RST = '{
        state:    ST_IDLE,
        sample:   32'd0,
        scaler:   32'd1,
        shiftreg: 9'h1ff,
        bitpos:   4'd0,
        par:      1'b0,
        par_en:   1'b0,
        stop2:    1'b0,
        tx:       1'b1,
        overflow: 1'b0
    };

endpackage

// File: rtl/vip_uart_tx_ext_if.sv
// rtl/vip_uart_tx_ext_if.sv - write handshake into the UART TX VIP FIFO
interface vip_uart_tx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic                 we;
    logic [DATA_BITS-1:0] wdata;
    logic                 wready;

    modport master (output we, output wdata, input wready);
    modport slave  (input we, input wdata, output wready);
endinterface

// File: rtl/vip_uart_tx_fifo.sv
// rtl/vip_uart_tx_fifo.sv - synchronous FIFO with occupancy count, full and empty flags
module vip_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LOG2:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG2;
    localparam int CNT_W = LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2-1:0]  wr_ptr;
    logic [LOG2-1:0]  rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Callers gate push with !full and pop with !empty; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vip_uart_tx_ext.sv
// rtl/vip_uart_tx_ext.sv - FIFO-fed UART transmitter with runtime parity/stop selection
// Optional line-break hold-off input is enabled by VIP_UART_TX_BREAK_EN.
module vip_uart_tx_ext
    import vip_uart_tx_ext_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_LOG2    = 2,
    parameter int SCALER_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SCALER_WIDTH-1:0] i_scaler,
    input  logic                    i_parity_en,
    input  logic                    i_parity_odd,
    input  logic                    i_stop2,
    vip_uart_tx_ext_if.slave        wr,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic                    o_overflow,
    input  logic                    i_clr_ovf,
    output logic [FIFO_LOG2:0]      o_fifo_cnt
`ifdef VIP_UART_TX_BREAK_EN
    ,
    input  logic                    i_break
`endif
);
    tx_regs_t             r;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 brk;
    logic                 bit_end;
    logic [8:0]           load_sr;
    logic [31:0]          scaler_eff;

`ifdef VIP_UART_TX_BREAK_EN
    assign brk = i_break;
`else
    assign brk = 1'b0;
`endif

    // Full is the registered count, so a write on a full cycle is dropped even if a pop happens.
    assign push       = wr.we && !fifo_full;
    assign pop        = (r.state == ST_IDLE) && !fifo_empty && !brk;
    assign bit_end    = (r.sample == r.scaler - 32'd1);
    assign scaler_eff = (i_scaler == '0) ? 32'd1 : 32'(i_scaler);

    always_comb begin
        load_sr                 = '1;
        load_sr[DATA_BITS-1:0]  = head;
    end

    vip_uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (wr.wdata),
        .pop       (pop),
        .head      (head),
        .count     (o_fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // tx is registered from the current state, so the line lags the state by one clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r <= TX_REGS_RST;
        end else begin
            r.overflow <= (wr.we && fifo_full) || (r.overflow && !i_clr_ovf);
            if (r.state != ST_IDLE) begin
                r.sample <= bit_end ? 32'd0 : r.sample + 32'd1;
            end
            case (r.state)
                ST_IDLE: begin
                    r.tx <= !brk;
                    if (pop) begin
                        r.state    <= ST_START;
                        r.sample   <= 32'd0;
                        r.bitpos   <= 4'd0;
                        r.shiftreg <= load_sr;
                        r.par      <= (^head) ^ i_parity_odd;
                        r.par_en   <= i_parity_en;
                        r.stop2    <= i_stop2;
                        r.scaler   <= scaler_eff;
                    end
                end
                ST_START: begin
                    r.tx <= 1'b0;
                    if (bit_end) begin
                        r.state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r.tx <= r.shiftreg[0];
                    if (bit_end) begin
                        r.shiftreg <= {1'b1, r.shiftreg[8:1]};
                        if (r.bitpos == 4'(DATA_BITS - 1)) begin
                            r.bitpos <= 4'd0;
                            r.state  <= r.par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            r.bitpos <= r.bitpos + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    r.tx <= r.par;
                    if (bit_end) begin
                        r.state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    r.tx <= 1'b1;
                    // bitpos counts stop bits already sent
                    if (bit_end) begin
                        if (r.stop2 && r.bitpos == 4'd0) begin
                            r.bitpos <= 4'd1;
                        end else begin
                            r.bitpos <= 4'd0;
                            r.state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r.state <= ST_IDLE;
                    r.tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx       = r.tx;
    assign o_overflow = r.overflow;
    assign o_busy     = (r.state != ST_IDLE) || !fifo_empty;
    assign wr.wready  = !fifo_full;
endmodule

// File: tb/tb_vip_uart_tx_ext.sv
// tb/tb_vip_uart_tx_ext.sv - self-checking bench for vip_uart_tx_ext (8-bit and 5-bit instances)
module tb_vip_uart_tx_ext;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] scaler;
    logic        pe, po, s2, clr;
    logic        tx8, busy8, ovf8, tx5, busy5, ovf5;
    logic [2:0]  cnt8, cnt5;
`ifdef VIP_UART_TX_BREAK_EN
    logic        brk;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    vip_uart_tx_ext_if #(.DATA_BITS(8)) wr8 ();
    vip_uart_tx_ext_if #(.DATA_BITS(5)) wr5 ();

    always #5 clk = ~clk;

    vip_uart_tx_ext #(.DATA_BITS(8), .FIFO_LOG2(2), .SCALER_WIDTH(32)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_scaler(scaler), .i_parity_en(pe),
        .i_parity_odd(po), .i_stop2(s2), .wr(wr8.slave), .o_tx(tx8),
        .o_busy(busy8), .o_overflow(ovf8), .i_clr_ovf(clr), .o_fifo_cnt(cnt8)
`ifdef VIP_UART_TX_BREAK_EN
        , .i_break(brk)
`endif
    );

    vip_uart_tx_ext #(.DATA_BITS(5), .FIFO_LOG2(2), .SCALER_WIDTH(32)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_scaler(scaler), .i_parity_en(pe),
        .i_parity_odd(po), .i_stop2(s2), .wr(wr5.slave), .o_tx(tx5),
        .o_busy(busy5), .o_overflow(ovf5), .i_clr_ovf(clr), .o_fifo_cnt(cnt5)
`ifdef VIP_UART_TX_BREAK_EN
        , .i_break(brk)
`endif
    );

    typedef struct {
        int         sel;
        logic [8:0] data;
        int         sc;
        bit         pe;
        bit         po;
        bit         s2;
        int         len;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Line image of one frame: start, payload LSB first, optional parity, stop bit(s).
    function automatic void build_wave(input logic [8:0] d, input int nb, input int sc,
                                       input bit pe_, input bit po_, input bit s2_,
                                       output bit w[$]);
        bit bits[$];
        bit p;
        int per;
        per = (sc == 0) ? 1 : sc;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pe_) bits.push_back(p ^ po_);
        bits.push_back(1'b1);
        if (s2_) bits.push_back(1'b1);
        w = {};
        foreach (bits[i]) begin
            for (int k = 0; k < per; k++) w.push_back(bits[i]);
        end
    endfunction

    // Cycle c issues scheduled writes; the line is then sampled. First write at c=0 shows its
    // start bit at sample c=2; the block reports idle again at sample c=len+1.
    task automatic run_check(input string name, input int sel, input int wr_c[$],
                             input logic [8:0] wr_d[$], input bit exp_rdy[$], input int clr_c,
                             input int cnt_c, input int cnt_exp, input bit wave[$],
                             output int len);
        int   wi, bad, first_bad;
        bit   exp;
        logic got, bz;
        wi = 0; bad = 0; first_bad = -1; len = -1;
        for (int c = 0; c < wave.size() + 8; c++) begin
            wr8.we = 1'b0;
            wr5.we = 1'b0;
            clr = (c == clr_c);
            if (wi < wr_c.size() && wr_c[wi] == c) begin
                chk($sformatf("%s wready%0d", name, wi),
                    32'(sel != 0 ? wr5.wready : wr8.wready), 32'(exp_rdy[wi]));
                if (sel != 0) begin
                    wr5.we = 1'b1; wr5.wdata = wr_d[wi][4:0];
                end else begin
                    wr8.we = 1'b1; wr8.wdata = wr_d[wi][7:0];
                end
                wi++;
            end
            tick();
            got = (sel != 0) ? tx5 : tx8;
            bz  = (sel != 0) ? busy5 : busy8;
            exp = (c < 2) ? 1'b1 : ((c - 2 < wave.size()) ? wave[c - 2] : 1'b1);
            if (got !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (c >= 1 && len < 0 && bz === 1'b0) len = c - 1;
            if (c == cnt_c)
                chk($sformatf("%s fifo_cnt", name), 32'(sel != 0 ? cnt5 : cnt8), 32'(cnt_exp));
        end
        wr8.we = 1'b0;
        wr5.we = 1'b0;
        clr = 1'b0;
        chk($sformatf("%s wave bad samples (first at %0d)", name, first_bad), 32'(bad), 32'd0);
    endtask

    initial begin
        vec_t       tbl[6];
        bit         wave[$];
        bit         fw[$];
        int         wc[$];
        logic [8:0] wd[$];
        bit         rdy[$];
        int         len, low, bz, bad;
        int         sel;

        tbl[0] = '{sel: 0, data: 9'h055, sc: 4, pe: 0, po: 0, s2: 0, len: 40};
        tbl[1] = '{sel: 0, data: 9'h003, sc: 4, pe: 1, po: 1, s2: 1, len: 48};
        tbl[2] = '{sel: 0, data: 9'h0A5, sc: 1, pe: 1, po: 0, s2: 0, len: 11};
        tbl[3] = '{sel: 0, data: 9'h080, sc: 3, pe: 0, po: 0, s2: 1, len: 33};
        tbl[4] = '{sel: 1, data: 9'h01F, sc: 0, pe: 0, po: 0, s2: 0, len: 7};
        tbl[5] = '{sel: 1, data: 9'h00A, sc: 2, pe: 1, po: 1, s2: 1, len: 18};

        rst = 1'b1; scaler = 32'd4; pe = 0; po = 0; s2 = 0; clr = 0;
        wr8.we = 0; wr8.wdata = '0; wr5.we = 0; wr5.wdata = '0;
`ifdef VIP_UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) tick();
        chk("reset tx", 32'(tx8), 32'd1);
        chk("reset wready", 32'(wr8.wready), 32'd1);
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset overflow", 32'(ovf8), 32'd0);
        chk("reset fifo_cnt", 32'(cnt8), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            scaler = tbl[i].sc; pe = tbl[i].pe; po = tbl[i].po; s2 = tbl[i].s2;
            build_wave(tbl[i].data, tbl[i].sel != 0 ? 5 : 8, tbl[i].sc,
                       tbl[i].pe, tbl[i].po, tbl[i].s2, wave);
            wc = {0}; wd = {tbl[i].data}; rdy = {1'b1};
            run_check($sformatf("vec%0d", i), tbl[i].sel, wc, wd, rdy, -1, 0, 1, wave, len);
            chk($sformatf("vec%0d frame length", i), 32'(len), 32'(tbl[i].len));
        end

        // Burst while a frame is on the line: four fit, the fifth overflows with clear in the same cycle.
        scaler = 32'd2; pe = 0; po = 0; s2 = 0;
        wc  = {0, 5, 6, 7, 8, 9};
        wd  = {9'h03C, 9'h001, 9'h080, 9'h0F0, 9'h05A, 9'h0EE};
        rdy = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wave = {};
        for (int i = 0; i < 5; i++) begin
            build_wave(wd[i], 8, 2, 1'b0, 1'b0, 1'b0, fw);
            if (i > 0) wave.push_back(1'b1);
            wave = {wave, fw};
        end
        run_check("burst", 0, wc, wd, rdy, 9, 9, 4, wave, len);
        chk("burst total length", 32'(len), 32'(5 * 20 + 4));
        chk("burst overflow sticky", 32'(ovf8), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0; tick();
        chk("overflow cleared", 32'(ovf8), 32'd0);

        // Reset during the data bits of a zero byte with a second byte queued.
        scaler = 32'd2;
        wr8.we = 1'b1; wr8.wdata = 8'h00; tick();
        wr8.wdata = 8'hFF; tick();
        wr8.we = 1'b0;
        repeat (6) tick();
        chk("pre-reset tx in data", 32'(tx8), 32'd0);
        chk("pre-reset fifo_cnt", 32'(cnt8), 32'd1);
        rst = 1'b1; tick();
        chk("mid-reset tx", 32'(tx8), 32'd1);
        chk("mid-reset fifo_cnt", 32'(cnt8), 32'd0);
        chk("mid-reset busy", 32'(busy8), 32'd0);
        rst = 1'b0;
        low = 0; bz = 0;
        repeat (60) begin
            tick();
            if (tx8 !== 1'b1) low++;
            if (busy8 !== 1'b0) bz++;
        end
        chk("post-reset tx low samples", 32'(low), 32'd0);
        chk("post-reset busy samples", 32'(bz), 32'd0);

        for (int i = 0; i < 12; i++) begin
            sel    = int'($urandom_range(0, 1));
            scaler = $urandom_range(0, 4);
            pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
            wd = {9'($urandom)};
            build_wave(wd[0], sel != 0 ? 5 : 8, int'(scaler), pe, po, s2, wave);
            wc = {0}; rdy = {1'b1};
            run_check($sformatf("rand%0d", i), sel, wc, wd, rdy, -1, 0, 1, wave, len);
            chk($sformatf("rand%0d frame length", i), 32'(len), 32'(wave.size()));
        end

`ifdef VIP_UART_TX_BREAK_EN
        scaler = 32'd2; pe = 0; po = 0; s2 = 0;
        brk = 1'b1; bad = 0;
        for (int c = 0; c < 20; c++) begin
            wr8.we = (c == 1); wr8.wdata = 8'hC3;
            tick();
            if (tx8 !== 1'b0) bad++;
        end
        wr8.we = 1'b0;
        chk("break low samples wrong", 32'(bad), 32'd0);
        chk("break byte queued", 32'(cnt8), 32'd1);
        brk = 1'b0; tick();
        chk("break release tx", 32'(tx8), 32'd1);
        build_wave(9'h0C3, 8, 2, 1'b0, 1'b0, 1'b0, wave);
        bad = 0;
        foreach (wave[i]) begin
            tick();
            if (tx8 !== wave[i]) bad++;
        end
        chk("break frame after release", 32'(bad), 32'd0);
        repeat (4) tick();
        chk("break done busy", 32'(busy8), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
